// File: rtl/mac_pkg.sv
// Shared types and default widths for the mac_accum multiply-accumulate slice.
package mac_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam int LEN_DEF   = 16;
  localparam int GUARD_DEF = 8;
  localparam int CNT_W_DEF = 16;

  function automatic int acc_width(input int len, input int guard);
    return 2 * len + guard;
  endfunction

  localparam int ACC_W_DEF = acc_width(LEN_DEF, GUARD_DEF);

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_mul.sv
// Combinational signed LEN x LEN -> 2*LEN multiplier feeding the mac_accum product register.
module mac_mul #(
  parameter int LEN = 16
) (
  input  logic signed [LEN-1:0]   a,
  input  logic signed [LEN-1:0]   b,
  output logic signed [2*LEN-1:0] p
);

  // Widen both operands first so the full signed product is kept.
  assign p = (2*LEN)'(a) * (2*LEN)'(b);

endmodule

// File: rtl/mac_accum.sv
// Burst multiply-accumulate: registered product, wide accumulator, one result per in_last burst.
// Define MAC_ACCUM_SATURATE_EN to clamp the accumulator on signed overflow instead of wrapping.
module mac_accum
  import mac_pkg::*;
#(
  parameter int  LEN   = LEN_DEF,
  parameter int  GUARD = GUARD_DEF,
  parameter int  CNT_W = CNT_W_DEF,
  localparam int ACC_W = acc_width(LEN, GUARD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [LEN-1:0]   in_a,
  input  logic signed [LEN-1:0]   in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf,
  output state_e                  dbg_state
);

  // Handshake: a beat/result transfers on the rising edge where valid && ready are both high;
  // valid may not depend on ready, and operands are ignored in any cycle without a transfer.

  state_e state_q, state_d;
  logic   run_q;
  logic   accept, last_pending, clear;

  logic signed [2*LEN-1:0] prod, p_q;
  logic                    p_v, p_last;

  logic signed [ACC_W-1:0] acc_q, p_ext, sum_raw, sum_next;
  logic [CNT_W-1:0]        cnt_q, cnt_next;
  logic                    ovf_q, add_ovf, ovf_next;

  mac_mul #(.LEN(LEN)) u_mul (
    .a (in_a),
    .b (in_b),
    .p (prod)
  );

  assign accept       = in_valid && in_ready;
  assign last_pending = p_v && p_last;
  assign clear        = (state_q == DONE) && out_ready;
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // run_q keeps in_ready low while reset is asserted.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = run_q && !last_pending;
        if (last_pending) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    p_ext    = ACC_W'(p_q);
    sum_raw  = acc_q + p_ext;
    add_ovf  = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
    ovf_next = ovf_q | add_ovf;
    cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef MAC_ACCUM_SATURATE_EN
    // Clamp toward the side the product pushed us; a later opposite add re-enters range.
    if (add_ovf) sum_next = p_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else         sum_next = sum_raw;
`else
    sum_next = sum_raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      p_v    <= 1'b0;
      p_last <= 1'b0;
    end else if (accept) begin
      p_q    <= prod;
      p_v    <= 1'b1;
      p_last <= in_last;
    end else begin
      p_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (p_v) begin
      acc_q <= sum_next;
      cnt_q <= cnt_next;
      ovf_q <= ovf_next;
    end
  end

  // Result registers capture the sum including the final product and hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (last_pending && state_q == ACC) begin
      out_acc   <= sum_next;
      out_count <= cnt_next;
      out_ovf   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// Directed self-checking bench for mac_accum (default widths plus a LEN=4/GUARD=0 overflow instance).
module tb_mac_accum;
  import mac_pkg::*;

  logic clk, rst_n;

  logic               in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic signed [15:0] in_a, in_b;
  logic signed [39:0] out_acc;
  logic [15:0]        out_count;
  state_e             dbg_state;

  logic              s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_ovf;
  logic signed [3:0] s_in_a, s_in_b;
  logic signed [7:0] s_out_acc;
  logic [15:0]       s_out_count;
  state_e            s_dbg_state;

  int vectors = 0;
  int errors  = 0;
  logic signed [39:0] exp_q[$];

  mac_accum dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  mac_accum #(.LEN(4), .GUARD(0), .CNT_W(16)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_acc(s_out_acc),
    .out_count(s_out_count), .out_ovf(s_out_ovf), .dbg_state(s_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drivers: entered and left on a falling edge.
  task automatic send_beat(input int a, input int b, input bit last);
    int n = 0;
    in_a = 16'(a); in_b = 16'(b); in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", (n < 50) ? 1 : 0, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("result_wait", (n < 50) ? 1 : 0, 1);
  endtask

  task automatic check_acc(input string tag);
    logic signed [39:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_exp_queue"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check(tag, out_acc, e);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_in_a = '0; s_in_b = '0; s_out_ready = 1'b1;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_state", dbg_state, ACC);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // three-beat burst: 12 - 10 - 7 = -5, result two cycles after the last beat
    exp_q.push_back(-40'sd5);
    send_beat(3, 4, 0);
    send_beat(-2, 5, 0);
    send_beat(7, -1, 1);
    check("t1_bubble_ready", in_ready, 0);
    check("t1_valid_n1", out_valid, 0);
    @(negedge clk);
    check("t1_valid_n2", out_valid, 1);
    check("t1_state_done", dbg_state, DONE);
    check_acc("t1_acc");
    check("t1_count", out_count, 3);
    check("t1_ovf", out_ovf, 0);
    @(negedge clk);
    check("t1_valid_drop", out_valid, 0);
    check("t1_ready_back", in_ready, 1);

    // single most-negative square, then hold the result with out_ready low
    out_ready = 1'b0;
    exp_q.push_back(40'sd1073741824);
    send_beat(-32768, -32768, 1);
    wait_result();
    check_acc("t2_acc");
    check("t2_count", out_count, 1);
    check("t2_ovf", out_ovf, 0);

    in_a = 16'sd2; in_b = 16'sd3; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_ready", in_ready, 0);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_acc", out_acc, 40'sd1073741824);
      check("t3_hold_count", out_count, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_drop", out_valid, 0);
    check("t3_ready_next", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    exp_q.push_back(40'sd6);
    wait_result();
    check_acc("t3_acc");
    check("t3_count", out_count, 1);
    @(negedge clk);

    // reset in the middle of a burst discards the partial sum
    send_beat(5, 5, 0);
    send_beat(6, 6, 0);
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", out_valid, 0);
    check("t4_rst_ready", in_ready, 0);
    check("t4_rst_count", out_count, 0);
    @(negedge clk);
    check("t4_rst_valid_hold", out_valid, 0);
    rst_n = 1'b1;
    exp_q.push_back(40'sd1);
    send_beat(1, 1, 1);
    wait_result();
    check_acc("t4_acc");
    check("t4_count", out_count, 1);
    @(negedge clk);

    // in_valid toggling: four beats of 1*2 separated by idle cycles
    exp_q.push_back(40'sd8);
    for (int i = 0; i < 4; i++) begin
      send_beat(1, 2, i == 3);
      if (i < 3) begin
        in_a = 16'sd9; in_b = 16'sd9;
        @(negedge clk);
      end
    end
    wait_result();
    check_acc("t5_acc");
    check("t5_count", out_count, 4);
    check("t5_ovf", out_ovf, 0);
    @(negedge clk);

    // narrow instance: 64 + 64 overflows an 8-bit accumulator
    check("t6_ready", s_in_ready, 1);
    s_in_a = -4'sd8; s_in_b = -4'sd8; s_in_valid = 1'b1; s_in_last = 1'b0;
    @(negedge clk);
    s_in_last = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0; s_in_last = 1'b0;
    n = 0;
    while (!s_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_result_wait", (n < 50) ? 1 : 0, 1);
`ifdef MAC_ACCUM_SATURATE_EN
    check("t6_acc_sat", s_out_acc, 127);
`else
    check("t6_acc_wrap", s_out_acc, -128);
`endif
    check("t6_ovf", s_out_ovf, 1);
    check("t6_count", s_out_count, 2);
    @(negedge clk);
    check("t6_valid_drop", s_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mac_accum.md
Name: mac_accum

Overview:
- Sequential multiply-accumulate stage that consumes signed full-width products of two LEN-bit operands and sums them into a wide accumulator.
- Operands arrive on a valid/ready stream, grouped into dot-product bursts terminated by in_last.
- One registered result per burst is emitted on a second valid/ready stream.
- Sits directly downstream of the combinational signed multiplier; it instantiates that multiplier and registers its product.

Parameters:
- LEN, 16, operand width; product width is 2*LEN.
- GUARD, 8, accumulator guard bits; ACC_W = 2*LEN+GUARD.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  operand beat accepted when in_valid && in_ready.
- in_a  input  LEN  signed operand A.
- in_b  input  LEN  signed operand B.
- in_last  input  1  marks the final beat of a burst.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_acc  output  ACC_W  signed burst sum.
- out_count  output  CNT_W  number of beats in the burst; saturates at all-ones.
- out_ovf  output  1  sticky: the burst sum exceeded the signed ACC_W range.

Behaviour:
- Reset (asynchronous, active-low) clears the following to 0 and forces state ACC:
  - in_ready and all outputs
  - product register, accumulator, counter and overflow flag
- Reset mid-burst discards all partial state; there is no recovery.
- Stage 1, product register:
  - On an accepted beat, p_q <= signed(in_a)*signed(in_b) (2*LEN bits), p_v <= 1, p_last <= in_last.
  - Otherwise p_v <= 0.
- Stage 2, accumulate:
  - When p_v is set, acc <= acc + sign-extend(p_q) to ACC_W, and the count increments (saturating).
  - The overflow flag is set when the signed add overflows ACC_W.
- States:
  - ACC: in_ready = !(p_v && p_last). When p_v && p_last, out_acc/out_count/out_ovf load the final sum (including this product) and the state moves to DONE.
  - DONE: out_valid = 1, in_ready = 0, outputs held stable. On out_ready, the accumulator, count and flag clear to 0, out_valid drops the next cycle, and the state returns to ACC.
- Latency:
  - A last beat accepted in cycle N gives out_valid high in cycle N+2.
  - The earliest next-burst acceptance is the cycle after the handshake.
- Throughput: 1 beat/cycle inside a burst. The cycle after a last beat is accepted, in_ready = 0 (a single bubble).
- Single-beat burst (in_last on the first beat): out_count = 1 and out_acc = that product.
- Operand ports are ignored when not accepted; in_valid may drop mid-burst without effect.
- Without the optional feature, accumulation wraps modulo 2^ACC_W; out_ovf still reports the overflow.

Optional Feature:
- Macro MAC_ACCUM_SATURATE_EN.
- When defined: on signed overflow the accumulator clamps to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)) according to the product sign. It stays clamped in that direction until a later add brings it back in range. out_ovf is still set.
- When undefined: two's-complement wrap as described in Behaviour.

Decomposition:
- Package mac_pkg holds:
  - state enum {ACC, DONE}
  - localparams for the default LEN, GUARD and CNT_W
  - ACC_W derivation, plus max/min accumulator constants
- One sub-module, mac_mul: a combinational signed LEN x LEN -> 2*LEN multiplier, instantiated once in stage 1.

Test Plan:
- Burst (3,4),(−2,5),(7,−1) with last on beat 3, out_ready=1 -> out_acc=−5, out_count=3, out_ovf=0; out_valid 2 cycles after the last beat.
- Single beat (−32768,−32768), last=1 -> out_acc=1073741824, out_count=1.
- Result backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, outputs stable; release -> next burst accepted the cycle after the handshake.
- Overflow with GUARD=0, LEN=4: beats (−8,−8),(−8,−8) last:
  - undefined: out_acc=−128 (wrapped), out_ovf=1
  - MAC_ACCUM_SATURATE_EN: out_acc=127, out_ovf=1
- Assert rst_n low mid-burst after 2 beats, release, send (1,1) last -> out_acc=1, out_count=1; out_valid low during reset.
- Gapped input, in_valid toggling every cycle over 4 beats of (1,2) -> out_acc=8, out_count=4.
